// File: rtl/b2p_pkg.sv
// Shared types and constants for the B2P pixel output path.
package b2p_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StVsync,
    StHsync,
    StActive,
    StHblank,
    StVblank
  } pixel_sched_state_t;

  // Valid-pixel codes carried on p_odd for the last beat of a line
  localparam logic [1:0] P_ODD_ALL = 2'b00;
  localparam logic [1:0] P_ODD_1   = 2'b01;
  localparam logic [1:0] P_ODD_2   = 2'b10;
  localparam logic [1:0] P_ODD_3   = 2'b11;

  // log2 of the supported pixels-per-beat values (1, 2, 4)
  function automatic int unsigned log2_np(input int unsigned np);
    if (np >= 4) return 2;
    if (np >= 2) return 1;
    return 0;
  endfunction

endpackage

// File: rtl/pixel_sched_cnt.sv
// Loadable saturating down-counter; done is high while the count is zero.
module pixel_sched_cnt #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             dec,
  output logic             done
);

  localparam logic [Width-1:0] One = Width'(1);

  logic [Width-1:0] cnt_q, cnt_d;

  // Load has priority over decrement; decrement stops at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - One;
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/pixel_out_sched.sv
// Paces upstream pixel beats into frames with sync pulses, blanking and
// per-line partial-word marking.
module pixel_out_sched
  import b2p_pkg::*;
#(
  parameter int unsigned NUM_PIXELS   = 1,
  parameter int unsigned PD_BUS_WIDTH = 16,
  parameter int unsigned NUM_TX_CH    = 1,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned VS_WIDTH     = 4,
  parameter int unsigned HS_WIDTH     = 2
) (
  input  logic                              clk_pixel_i,
  input  logic                              reset_pixel_i,
  input  logic                              enable_i,
  input  logic [CNT_W-1:0]                  h_active_i,
  input  logic [CNT_W-1:0]                  v_active_i,
  input  logic [CNT_W-1:0]                  h_blank_i,
  input  logic [CNT_W-1:0]                  v_blank_i,
  input  logic                              in_valid_i,
  input  logic [PD_BUS_WIDTH*NUM_TX_CH-1:0] in_data_i,
  output logic                              in_ready_o,
  output logic [PD_BUS_WIDTH*NUM_TX_CH-1:0] pixel_data_o,
  output logic [1:0]                        p_odd_o,
  output logic                              de_o,
  output logic                              line_valid_o,
  output logic                              frame_valid_o,
  output logic                              vsync_o,
  output logic                              hsync_o,
  output logic                              underflow_o,
  output logic                              config_err_o
);

  localparam int unsigned     DW      = PD_BUS_WIDTH * NUM_TX_CH;
  localparam int unsigned     NpLog2  = log2_np(NUM_PIXELS);
  localparam logic [CNT_W:0]  NpRound = (CNT_W + 1)'(NUM_PIXELS - 1);
  localparam logic [CNT_W:0]  OneExt  = (CNT_W + 1)'(1);
  localparam logic [CNT_W-1:0] One    = CNT_W'(1);
  localparam logic [CNT_W-1:0] VsLoad = CNT_W'(VS_WIDTH - 1);
  localparam logic [CNT_W-1:0] HsLoad = CNT_W'(HS_WIDTH - 1);

  pixel_sched_state_t state_q, state_d;

  logic [CNT_W-1:0] h_active_q, v_active_q, h_blank_q, v_blank_q;

  logic             in_ready_q, in_ready_d;
  logic [DW-1:0]    pixel_data_q, pixel_data_d;
  logic [1:0]       p_odd_q, p_odd_d;
  logic             de_q, de_d;
  logic             line_valid_q, line_valid_d;
  logic             frame_valid_q, frame_valid_d;
  logic             vsync_q, vsync_d;
  logic             hsync_q, hsync_d;
  logic             underflow_q, underflow_d;
  logic             config_err_q, config_err_d;

  logic             start, line_end, frame_end, latch, err_set;
  logic             sync_load, blank_load, beat_load, line_load, line_dec;
  logic [CNT_W-1:0] sync_val, blank_val;
  logic             sync_done, blank_done, beat_done, line_done;
  logic [CNT_W:0]   beats;
  logic [1:0]       p_odd_last;
  logic             hs;
  logic             cfg_ok;

  assign hs     = in_valid_i & in_ready_q;
  assign cfg_ok = (h_active_i != '0) && (v_active_i != '0);
  // Extra top bit keeps the round-up from wrapping at the maximum h_active
  assign beats  = ({1'b0, h_active_q} + NpRound) >> NpLog2;

  pixel_sched_cnt #(.Width(CNT_W)) u_sync_cnt (
    .clk      (clk_pixel_i),
    .rst      (reset_pixel_i),
    .load     (sync_load),
    .load_val (sync_val),
    .dec      (1'b1),
    .done     (sync_done)
  );

  pixel_sched_cnt #(.Width(CNT_W)) u_blank_cnt (
    .clk      (clk_pixel_i),
    .rst      (reset_pixel_i),
    .load     (blank_load),
    .load_val (blank_val),
    .dec      (1'b1),
    .done     (blank_done)
  );

  pixel_sched_cnt #(.Width(CNT_W + 1)) u_beat_cnt (
    .clk      (clk_pixel_i),
    .rst      (reset_pixel_i),
    .load     (beat_load),
    .load_val (beats - OneExt),
    .dec      (hs),
    .done     (beat_done)
  );

  pixel_sched_cnt #(.Width(CNT_W)) u_line_cnt (
    .clk      (clk_pixel_i),
    .rst      (reset_pixel_i),
    .load     (line_load),
    .load_val (v_active_i - One),
    .dec      (line_dec),
    .done     (line_done)
  );

  // Partial-word code for the last beat of a line
  always_comb begin
    p_odd_last = P_ODD_ALL;
    if (NUM_PIXELS == 4) begin
      unique case (h_active_q[1:0])
        2'd1:    p_odd_last = P_ODD_1;
        2'd2:    p_odd_last = P_ODD_2;
        2'd3:    p_odd_last = P_ODD_3;
        default: p_odd_last = P_ODD_ALL;
      endcase
    end else if (NUM_PIXELS == 2) begin
      p_odd_last = h_active_q[0] ? P_ODD_1 : P_ODD_ALL;
    end
  end

  // State register
  always_ff @(posedge clk_pixel_i or posedge reset_pixel_i) begin
    if (reset_pixel_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and counter control; line and frame ends are resolved after
  // the case so a zero-length blank falls straight through to the next phase
  always_comb begin
    state_d    = state_q;
    start      = 1'b0;
    line_end   = 1'b0;
    frame_end  = 1'b0;
    latch      = 1'b0;
    err_set    = 1'b0;
    sync_load  = 1'b0;
    sync_val   = VsLoad;
    blank_load = 1'b0;
    blank_val  = '0;
    beat_load  = 1'b0;
    line_load  = 1'b0;
    line_dec   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable_i) start = 1'b1;
      end
      StVsync: begin
        if (sync_done) begin
          state_d   = StHsync;
          sync_load = 1'b1;
          sync_val  = HsLoad;
        end
      end
      StHsync: begin
        if (sync_done) begin
          state_d   = StActive;
          beat_load = 1'b1;
        end
      end
      StActive: begin
        if (hs && beat_done) begin
          if (h_blank_q != '0) begin
            state_d    = StHblank;
            blank_load = 1'b1;
            blank_val  = h_blank_q - One;
          end else begin
            line_end = 1'b1;
          end
        end
      end
      StHblank: begin
        if (blank_done) line_end = 1'b1;
      end
      StVblank: begin
        if (blank_done) frame_end = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (line_end) begin
      if (!line_done) begin
        state_d   = StHsync;
        sync_load = 1'b1;
        sync_val  = HsLoad;
        line_dec  = 1'b1;
      end else if (v_blank_q != '0) begin
        state_d    = StVblank;
        blank_load = 1'b1;
        blank_val  = v_blank_q - One;
      end else begin
        frame_end = 1'b1;
      end
    end

    if (frame_end) begin
      if (enable_i) start = 1'b1;
      else          state_d = StIdle;
    end

    if (start) begin
      latch = 1'b1;
      if (cfg_ok) begin
        state_d   = StVsync;
        sync_load = 1'b1;
        sync_val  = VsLoad;
        line_load = 1'b1;
      end else begin
        err_set = 1'b1;
        state_d = StIdle;
      end
    end
  end

  // Output next-values; state-decoded outputs use state_d so they line up with state_q
  always_comb begin
    in_ready_d    = (state_d == StActive);
    vsync_d       = (state_d == StVsync);
    hsync_d       = (state_d == StHsync);
    frame_valid_d = (state_d == StHsync) || (state_d == StActive) || (state_d == StHblank);
    de_d          = hs;
    pixel_data_d  = hs ? in_data_i : pixel_data_q;
    p_odd_d       = (hs && beat_done) ? p_odd_last : P_ODD_ALL;
    line_valid_d  = hs | (line_valid_q & (state_q == StActive));
    underflow_d   = in_ready_q & ~in_valid_i;
    config_err_d  = config_err_q | err_set;
  end

  // Output registers
  always_ff @(posedge clk_pixel_i or posedge reset_pixel_i) begin
    if (reset_pixel_i) begin
      in_ready_q    <= 1'b0;
      pixel_data_q  <= '0;
      p_odd_q       <= P_ODD_ALL;
      de_q          <= 1'b0;
      line_valid_q  <= 1'b0;
      frame_valid_q <= 1'b0;
      vsync_q       <= 1'b0;
      hsync_q       <= 1'b0;
      underflow_q   <= 1'b0;
      config_err_q  <= 1'b0;
    end else begin
      in_ready_q    <= in_ready_d;
      pixel_data_q  <= pixel_data_d;
      p_odd_q       <= p_odd_d;
      de_q          <= de_d;
      line_valid_q  <= line_valid_d;
      frame_valid_q <= frame_valid_d;
      vsync_q       <= vsync_d;
      hsync_q       <= hsync_d;
      underflow_q   <= underflow_d;
      config_err_q  <= config_err_d;
    end
  end

  // Config snapshot taken only at frame start
  always_ff @(posedge clk_pixel_i or posedge reset_pixel_i) begin
    if (reset_pixel_i) begin
      h_active_q <= '0;
      v_active_q <= '0;
      h_blank_q  <= '0;
      v_blank_q  <= '0;
    end else if (latch) begin
      h_active_q <= h_active_i;
      v_active_q <= v_active_i;
      h_blank_q  <= h_blank_i;
      v_blank_q  <= v_blank_i;
    end
  end

  assign in_ready_o    = in_ready_q;
  assign pixel_data_o  = pixel_data_q;
  assign p_odd_o       = p_odd_q;
  assign de_o          = de_q;
  assign line_valid_o  = line_valid_q;
  assign frame_valid_o = frame_valid_q;
  assign vsync_o       = vsync_q;
  assign hsync_o       = hsync_q;
  assign underflow_o   = underflow_q;
  assign config_err_o  = config_err_q;

endmodule

// File: tb/tb_pixel_out_sched.sv
// Directed bench for pixel_out_sched: one 1-pixel instance for framing and
// flow control, one 4-pixel instance for partial-word codes.
module tb_pixel_out_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 1-pixel instance
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [15:0] h_act, v_act, h_blk, v_blk;
  logic        valid = 1'b0;
  logic [15:0] data;
  logic        ready, lv, fv, vs, hs, de, uf, cerr;
  logic [15:0] pix;
  logic [1:0]  podd;

  // 4-pixel instance
  logic        rst4 = 1'b1;
  logic        en4 = 1'b0;
  logic [15:0] h4, v4, hb4, vb4;
  logic        valid4 = 1'b0;
  logic [15:0] data4;
  logic        ready4, lv4, fv4, vs4, hs4, de4, uf4, cerr4;
  logic [15:0] pix4;
  logic [1:0]  podd4;

  pixel_out_sched #(.NUM_PIXELS(1)) dut1 (
    .clk_pixel_i   (clk),
    .reset_pixel_i (rst),
    .enable_i      (en),
    .h_active_i    (h_act),
    .v_active_i    (v_act),
    .h_blank_i     (h_blk),
    .v_blank_i     (v_blk),
    .in_valid_i    (valid),
    .in_data_i     (data),
    .in_ready_o    (ready),
    .pixel_data_o  (pix),
    .p_odd_o       (podd),
    .de_o          (de),
    .line_valid_o  (lv),
    .frame_valid_o (fv),
    .vsync_o       (vs),
    .hsync_o       (hs),
    .underflow_o   (uf),
    .config_err_o  (cerr)
  );

  pixel_out_sched #(.NUM_PIXELS(4)) dut4 (
    .clk_pixel_i   (clk),
    .reset_pixel_i (rst4),
    .enable_i      (en4),
    .h_active_i    (h4),
    .v_active_i    (v4),
    .h_blank_i     (hb4),
    .v_blank_i     (vb4),
    .in_valid_i    (valid4),
    .in_data_i     (data4),
    .in_ready_o    (ready4),
    .pixel_data_o  (pix4),
    .p_odd_o       (podd4),
    .de_o          (de4),
    .line_valid_o  (lv4),
    .frame_valid_o (fv4),
    .vsync_o       (vs4),
    .hsync_o       (hs4),
    .underflow_o   (uf4),
    .config_err_o  (cerr4)
  );

  // Incrementing source pattern: advances on each accepted beat
  logic [15:0] seq;
  always @(posedge clk or posedge rst) begin
    if (rst) seq <= '0;
    else if (valid && ready) seq <= seq + 16'd1;
  end
  assign data  = seq;
  assign data4 = 16'h0;

  // Event monitor sampled on the falling edge
  int          de_total = 0, hs_total = 0, vs_total = 0, uf_total = 0, rdy_total = 0;
  int          data_bad = 0;
  logic [15:0] exp_seq = '0;
  logic        hs_prev = 1'b0, vs_prev = 1'b0;
  always @(negedge clk) begin
    if (de === 1'b1) de_total <= de_total + 1;
    if (uf === 1'b1) uf_total <= uf_total + 1;
    if (ready === 1'b1) rdy_total <= rdy_total + 1;
    if (hs === 1'b1 && !hs_prev) hs_total <= hs_total + 1;
    if (vs === 1'b1 && !vs_prev) vs_total <= vs_total + 1;
    hs_prev <= (hs === 1'b1);
    vs_prev <= (vs === 1'b1);
    if (rst) begin
      exp_seq <= '0;
    end else if (de === 1'b1) begin
      if (pix !== exp_seq) data_bad <= data_bad + 1;
      exp_seq <= exp_seq + 16'd1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int          hv[3];
    logic [1:0]  lastc[3];
    logic [1:0]  pc[3];
    int          n4, n, nde, nhs, nvs, nvh, fv_fall, vs2, rdy_fall, lv_fall;
    int          k_hs[2];
    logic        p_hs, p_vs, p_fv, p_rdy, p_lv;
    int          s_de, s_hs, s_vs, s_uf, s_rdy;

    h_act = 16'd8; v_act = 16'd2; h_blk = 16'd3; v_blk = 16'd5;
    h4 = 16'd10; v4 = 16'd1; hb4 = 16'd2; vb4 = 16'd2;
    hv[0] = 10; hv[1] = 9; hv[2] = 11;
    lastc[0] = 2'b10; lastc[1] = 2'b01; lastc[2] = 2'b11;

    // Reset state of both instances
    step(); step();
    check("rst1_outs", {ready, lv, fv, vs, hs, de, uf, cerr, podd}, '0);
    check("rst1_pix", pix, '0);
    check("rst4_outs", {ready4, lv4, fv4, vs4, hs4, de4, uf4, cerr4, podd4}, '0);
    check("rst4_pix", pix4, '0);

    // 4-pixel instance: last-beat partial-word code for h_active 10, 9, 11
    valid4 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      rst4 = 1'b1;
      h4 = hv[c][15:0];
      step();
      rst4 = 1'b0;
      en4 = 1'b1;
      n4 = 0;
      for (int i = 0; i < 3; i++) pc[i] = 2'bxx;
      for (int k = 0; k < 20; k++) begin
        step();
        if (de4) begin
          if (n4 < 3) pc[n4] = podd4;
          n4++;
        end
      end
      en4 = 1'b0;
      check($sformatf("np4_h%0d_beats", hv[c]), n4, 3);
      check($sformatf("np4_h%0d_podd0", hv[c]), pc[0], 2'b00);
      check($sformatf("np4_h%0d_podd1", hv[c]), pc[1], 2'b00);
      check($sformatf("np4_h%0d_podd2", hv[c]), pc[2], lastc[c]);
    end

    // 1-pixel instance: basic frame timing, h=8 v=2 hb=3 vb=5
    rst = 1'b0;
    en = 1'b1;
    valid = 1'b1;
    nde = 0; nhs = 0; nvs = 0; nvh = 0;
    fv_fall = -1; vs2 = -1; rdy_fall = -1; lv_fall = -1;
    k_hs[0] = -100; k_hs[1] = -100;
    p_hs = 1'b0; p_vs = 1'b0; p_fv = 1'b0; p_rdy = 1'b0; p_lv = 1'b0;
    for (int k = 0; k <= 35; k++) begin
      step();
      if (k <= 34) begin
        if (de) nde++;
        if (vs) nvh++;
        if (hs && !p_hs) begin
          if (nhs < 2) k_hs[nhs] = k;
          nhs++;
        end
        if (vs && !p_vs) nvs++;
      end
      if (k > 0 && vs && !p_vs && vs2 < 0) vs2 = k;
      if (!fv && p_fv && fv_fall < 0) fv_fall = k;
      if (!ready && p_rdy && rdy_fall < 0) rdy_fall = k;
      if (!lv && p_lv && lv_fall < 0) lv_fall = k;
      p_hs = hs; p_vs = vs; p_fv = fv; p_rdy = ready; p_lv = lv;
    end
    check("frame_de_beats", nde, 16);
    check("frame_hsync_pulses", nhs, 2);
    check("frame_vsync_pulses", nvs, 1);
    check("vsync_width", nvh, 4);
    check("first_hsync_cycle", k_hs[0], 4);
    check("line_period", k_hs[1] - k_hs[0], 13);
    check("fv_fall_cycle", fv_fall, 30);
    check("vblank_to_vsync", vs2 - fv_fall, 5);
    check("ready_fall_cycle", rdy_fall, 14);
    check("lv_fall_cycle", lv_fall, 15);

    // Stall 4 cycles after three beats of the next line
    n = 0;
    while (!ready && n < 50) begin step(); n++; end
    check("wait_ready_uf", n < 50, 1'b1);
    step(); step(); step();
    s_uf = uf_total;
    valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("stall%0d_de", i), de, 1'b0);
      check($sformatf("stall%0d_lv", i), lv, 1'b1);
      check($sformatf("stall%0d_uf", i), uf, 1'b1);
    end
    valid = 1'b1;
    step();
    check("after_stall_uf", uf, 1'b0);
    check("after_stall_de", de, 1'b1);
    step(); step();
    check("uf_pulse_count", uf_total - s_uf, 4);
    v_act = 16'd3;

    // Next frame latches v_active=3; drop enable partway through line 1
    n = 0;
    while (!vs && n < 200) begin step(); n++; end
    check("wait_vsync_f3", n < 200, 1'b1);
    n = 0;
    while (!ready && n < 50) begin step(); n++; end
    check("wait_ready_f3", n < 50, 1'b1);
    s_de = de_total; s_hs = hs_total; s_vs = vs_total;
    step(); step(); step(); step();
    en = 1'b0;
    for (int i = 0; i < 70; i++) step();
    check("f3_de_beats", de_total - s_de, 24);
    check("f3_more_hsync", hs_total - s_hs, 2);
    check("f3_no_vsync", vs_total - s_vs, 0);
    check("f3_idle_fv", fv, 1'b0);
    check("f3_idle_ready", ready, 1'b0);
    check("data_no_loss", data_bad, 0);
    check("data_count", exp_seq, seq);

    // Zero h_active at enable
    h_act = 16'd0;
    en = 1'b1;
    s_vs = vs_total; s_rdy = rdy_total;
    for (int i = 0; i < 10; i++) step();
    check("cfg_err_set", cerr, 1'b1);
    check("cfg_err_no_vsync", vs_total - s_vs, 0);
    check("cfg_err_no_ready", rdy_total - s_rdy, 0);
    h_act = 16'd8;
    for (int i = 0; i < 10; i++) step();
    check("cfg_err_sticky", cerr, 1'b1);

    // Asynchronous reset in the middle of ACTIVE
    n = 0;
    while (!ready && n < 100) begin step(); n++; end
    check("wait_ready_rst", n < 100, 1'b1);
    step(); step();
    #2;
    rst = 1'b1;
    #1;
    check("arst_ready_de_lv", {ready, de, lv}, 3'b000);
    check("arst_fv_sync", {fv, vs, hs}, 3'b000);
    check("arst_uf_err_podd", {uf, cerr, podd}, 4'b0000);
    check("arst_pix", pix, '0);
    step();
    rst = 1'b0;
    step();
    check("restart_vsync", vs, 1'b1);
    for (int i = 0; i < 6; i++) step();
    check("restart_ready", ready, 1'b1);
    for (int i = 0; i < 60; i++) step();
    check("restart_cfg_err", cerr, 1'b0);
    check("restart_data_ok", data_bad, 0);
    check("restart_data_count", exp_seq, seq);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pixel_out_sched.md
# pixel_out_sched

Synthesizable scheduler on the receive side of the B2P pixel path. It pulls pixel beats from the upstream byte-to-pixel line buffer through a valid/ready handshake and paces them into frames. It generates frame_valid/line_valid for the CSI-2 flavour and de/vsync/hsync for the DSI flavour, with programmable blanking. On the last beat of each line it drives p_odd to mark the partially valid word.

## Interface
- NUM_PIXELS, 1, pixels per beat (1, 2 or 4)
- PD_BUS_WIDTH, 16, pixel-data width per TX channel
- NUM_TX_CH, 1, TX channels; data width is PD_BUS_WIDTH*NUM_TX_CH
- CNT_W, 16, width of all config counters
- VS_WIDTH, 4, vsync pulse length in cycles (≥1)
- HS_WIDTH, 2, hsync pulse length in cycles (≥1)

Ports:
- clk_pixel_i  in  1  pixel clock
- reset_pixel_i  in  1  reset, asynchronous, active-high
- enable_i  in  1  run frames while high
- h_active_i  in  CNT_W  pixels per line
- v_active_i  in  CNT_W  lines per frame
- h_blank_i  in  CNT_W  idle cycles after each line
- v_blank_i  in  CNT_W  idle cycles after each frame
- in_valid_i  in  1  upstream beat available
- in_data_i  in  PD_BUS_WIDTH*NUM_TX_CH  upstream beat
- in_ready_o  out  1  beat accepted when in_valid_i & in_ready_o
- pixel_data_o  out  PD_BUS_WIDTH*NUM_TX_CH  registered pixel word
- p_odd_o  out  2  valid-pixel code for the current beat
- de_o  out  1  data enable
- line_valid_o  out  1  CSI-2 line valid
- frame_valid_o  out  1  CSI-2 frame valid
- vsync_o  out  1  DSI vsync pulse
- hsync_o  out  1  DSI hsync pulse
- underflow_o  out  1  one-cycle pulse per stalled active cycle
- config_err_o  out  1  sticky; zero h_active or v_active seen at frame start

## Operation
- States: IDLE, VSYNC, HSYNC, ACTIVE, HBLANK, VBLANK.
- IDLE: if enable_i=1, latch all four config inputs.
  - If h_active=0 or v_active=0: set config_err_o and stay in IDLE.
  - Otherwise go to VSYNC.
- VSYNC: vsync_o=1 for VS_WIDTH cycles, then HSYNC.
  - frame_valid_o rises on the first HSYNC cycle and stays high through the last HBLANK of the frame.
- HSYNC: hsync_o=1 for HS_WIDTH cycles, then ACTIVE.
- ACTIVE: in_ready_o=1.
  - beats = ceil(h_active/NUM_PIXELS); the beat counter advances only on a handshake.
  - If in_valid_i=0: de_o=0, line_valid_o stays high, underflow_o=1.
  - After the last beat, go to HBLANK.
- HBLANK: line_valid_o=0 for h_blank cycles (0 means skip the state).
  - If the line counter < v_active: go to HSYNC.
  - Otherwise: frame_valid_o drops and go to VBLANK.
- VBLANK: v_blank cycles (0 means skip).
  - If enable_i=1: re-latch config and go to VSYNC.
  - Otherwise: IDLE.
- Deasserting enable_i mid-frame never truncates the frame; it is sampled only in IDLE and at the end of VBLANK.
- p_odd_o is 0 on every beat except the last beat of a line, where it is h_active mod NUM_PIXELS:
  - NUM_PIXELS=4: 01 = pix0 only, 10 = pix0–1, 11 = pix0–2.
  - NUM_PIXELS=2: 1 = pix0 only.
  - NUM_PIXELS=1: always 0.
- Config changes outside the latch points have no effect on the frame in progress.

## Timing
- Reset values: every output 0 (in_ready_o=0; pixel_data_o all zeros); state IDLE; counters 0; config_err_o cleared.
  - Reset is asynchronous and takes effect mid-frame; the bench must tolerate truncated frames.
- Data latency: one cycle from a handshake to de_o, pixel_data_o and p_odd_o.
  - line_valid_o is registered, rising with the first de_o and falling on the cycle after the last de_o.
- in_ready_o is a registered function of state, so it is never combinationally dependent on in_valid_i.
  - It drops in the cycle immediately following the final handshake of the line.
- Simultaneous last beat and zero h_blank: the next cycle is HSYNC (or VBLANK at the last line).
- Minimum line period: HS_WIDTH + beats + h_blank cycles (no stalls).
- Counter arithmetic is unsigned CNT_W.
  - The beat count is computed as (h_active + NUM_PIXELS − 1) >> log2(NUM_PIXELS), with a one-bit extension so it cannot wrap at h_active = 2^CNT_W − 1.

## Structure
- Shared package b2p_pkg:
  - state enum pixel_sched_state_t;
  - p_odd encodings P_ODD_ALL, P_ODD_1, P_ODD_2, P_ODD_3;
  - the log2 helper for NUM_PIXELS.
- One sub-module, pixel_sched_cnt: a loadable down-counter with a done flag.
  - It is instanced for the sync-width, beat, blank and line counts.
- The FSM and output registers stay in the top module.

## Test plan
- NUM_PIXELS=1, h_active=8, v_active=2, h_blank=3, v_blank=5, in_valid_i held 1, enable_i held 1 throughout:
  - exactly 16 de_o beats, 2 hsync pulses and 1 vsync pulse per frame;
  - line period 2+8+3 = 13 cycles;
  - the second frame's VSYNC starts 5 cycles after frame_valid_o falls.
- NUM_PIXELS=4, h_active=10:
  - 3 beats per line with p_odd_o = 00, 00, 10.
  - With h_active=9: the last beat has p_odd_o=01.
  - With h_active=11: the last beat has p_odd_o=11.
- in_valid_i dropped for 4 cycles mid-line:
  - 4 underflow_o pulses;
  - de_o low for those cycles while line_valid_o stays 1;
  - no beat lost or duplicated (check against an incrementing data pattern).
- enable_i deasserted in the middle of line 1 of a 3-line frame:
  - all 3 lines complete, followed by VBLANK, then IDLE;
  - no further vsync_o.
- h_active=0 at enable:
  - config_err_o sets and stays set;
  - no vsync_o and no in_ready_o;
  - it clears only on reset.
- reset_pixel_i pulsed during ACTIVE: all outputs are 0 immediately (asynchronously), and a clean frame starts after release with enable_i=1.
